discharge_sequencer: RTL and testbench

Pulse-level scheduler for the EDM discharge power stage. It sequences each pulse through gap-voltage application, breakdown wait, timed discharge (Ton), dead time and deionization (Toff). It sits between the SPI command/config registers and the MOSFET drive logic (buck/res/deion). It gates which stage may drive the gap, so the stages never conduct simultaneously. It supports continuous run and single-shot discharge.

---
 rtl/edm_pkg.sv | 27 ++
 rtl/us_timer.sv | 50 +++++
 rtl/discharge_sequencer.sv | 176 +++++++++++++++++
 tb/tb_discharge_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edm_pkg.sv
// Shared definitions for the EDM discharge power-stage sequencer:
// state encoding and default timing constants.
package edm_pkg;

  // Default timing constants (50 MHz system clock).
  localparam int CLK_PER_US      = 50;
  localparam int DEAD_CYCLES     = 10;
  localparam int WAIT_TIMEOUT_US = 2000;

  // State encoding, also exported on state_o.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_BD   = 3'd1;
  localparam logic [2:0] ST_DISCHARGE = 3'd2;
  localparam logic [2:0] ST_DEAD_A    = 3'd3;
  localparam logic [2:0] ST_DEION     = 3'd4;
  localparam logic [2:0] ST_DEAD_B    = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WAIT_BD   = ST_WAIT_BD,
    DISCHARGE = ST_DISCHARGE,
    DEAD_A    = ST_DEAD_A,
    DEION     = ST_DEION,
    DEAD_B    = ST_DEAD_B
  } state_t;

endpackage

// File: rtl/us_timer.sv
// Shared interval timer: a microsecond prescaler feeding a 16-bit counter.
// In us mode the interval is load*CLK_PER_US cycles; in raw mode the
// counter advances every cycle and the interval is load cycles.
// done marks the last cycle of the interval, near_done the one before it.
module us_timer #(
  parameter int CLK_PER_US = edm_pkg::CLK_PER_US
) (
  input  logic        clk_in,
  input  logic        sys_rst_n,
  input  logic        clr,
  input  logic        unit_us,
  input  logic [15:0] load,
  output logic        done,
  output logic        near_done
);

  localparam int              PRE_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);
  localparam logic [PRE_W-1:0] PRE_NEAR = PRE_W'(CLK_PER_US - 2);

  logic [PRE_W-1:0] pre;
  logic [15:0]      us_cnt;
  logic             last_unit;

  // Prescaler and unit counter; clr restarts the interval from zero.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    // NOTE: sequential state is only ever written with <= so every flop
    // samples the pre-edge values regardless of statement order.
    if (!sys_rst_n) begin
      pre    <= '0;
      us_cnt <= '0;
    end else if (clr) begin
      pre    <= '0;
      us_cnt <= '0;
    end else if (!unit_us) begin
      us_cnt <= us_cnt + 16'd1;
    end else if (pre == PRE_LAST) begin
      pre    <= '0;
      us_cnt <= us_cnt + 16'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign last_unit = (us_cnt == load - 16'd1);
  assign done      = unit_us ? ((pre == PRE_LAST) && last_unit) : last_unit;
  assign near_done = unit_us ? ((pre == PRE_NEAR) && last_unit)
                             : (us_cnt == load - 16'd2);

endmodule

// File: rtl/discharge_sequencer.sv
// Pulse-level scheduler for the EDM discharge stage. Walks each pulse
// through gap voltage, breakdown wait, timed discharge, dead time,
// deionization and a second dead time, enabling at most one power stage
// at a time. All outputs are registered and decoded from the next state.
module discharge_sequencer #(
  parameter int CLK_PER_US      = edm_pkg::CLK_PER_US,
  parameter int DEAD_CYCLES     = edm_pkg::DEAD_CYCLES,
  parameter int WAIT_TIMEOUT_US = edm_pkg::WAIT_TIMEOUT_US
) (
  input  logic        clk_in,
  input  logic        sys_rst_n,
  input  logic        start_cmd,
  input  logic        stop_cmd,
  input  logic        single_cmd,
  input  logic [15:0] ton_us,
  input  logic [15:0] toff_us,
  input  logic        is_breakdown,
  output logic        gap_en,
  output logic        discharge_en,
  output logic        deion_en,
  output logic        busy,
  output logic        pulse_done,
  output logic        open_circuit,
  output logic [15:0] pulse_count,
  output logic [2:0]  state_o
);

  import edm_pkg::*;

  localparam logic [15:0] TIMEOUT_LD = 16'(WAIT_TIMEOUT_US);
  localparam logic [15:0] DEAD_LD    = 16'(DEAD_CYCLES);

  state_t      state, state_next;
  logic        run, run_next;
  logic        single, single_next;
  logic [15:0] ton_q, toff_q;
  logic        cfg_ok;
  logic        tmr_clr, tmr_unit_us, tmr_done, tmr_near;
  logic [15:0] tmr_load;

  // The shadow registers are loaded on the same edge that enters WAIT_BD,
  // so the guard looks at the values about to be captured.
  assign cfg_ok  = (ton_us != 16'd0) && (toff_us != 16'd0);

  // Every state entry restarts the timebase; IDLE holds it cleared.
  assign tmr_clr = (state_next != state) || (state == IDLE);

  // Timer interval and unit for the current state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    tmr_load    = 16'd0;
    tmr_unit_us = 1'b1;
    case (state)
      WAIT_BD:   tmr_load = TIMEOUT_LD;
      DISCHARGE: tmr_load = ton_q;
      DEION:     tmr_load = toff_q;
      DEAD_A, DEAD_B: begin
        tmr_load    = DEAD_LD;
        tmr_unit_us = 1'b0;
      end
      default:   tmr_load = 16'd0;
    endcase
  end

  us_timer #(
    .CLK_PER_US (CLK_PER_US)
  ) u_timer (
    .clk_in    (clk_in),
    .sys_rst_n (sys_rst_n),
    .clr       (tmr_clr),
    .unit_us   (tmr_unit_us),
    .load      (tmr_load),
    .done      (tmr_done),
    .near_done (tmr_near)
  );

  // Next-state and mode-flag decode; stop beats start beats single.
  always_comb begin
    state_next  = state;
    run_next    = run;
    single_next = single;

    // While busy: stop always lets the current sequence wind down to IDLE,
    // start upgrades a single shot to continuous run, single is ignored.
    if (state != IDLE) begin
      if (stop_cmd) begin
        run_next    = 1'b0;
        single_next = 1'b0;
      end else if (start_cmd) begin
        run_next    = 1'b1;
        single_next = 1'b0;
      end
    end

    case (state)
      IDLE: begin
        if (stop_cmd) begin
          run_next    = 1'b0;
          single_next = 1'b0;
        end else if (start_cmd && cfg_ok) begin
          run_next   = 1'b1;
          state_next = WAIT_BD;
        end else if (single_cmd && cfg_ok) begin
          single_next = 1'b1;
          state_next  = WAIT_BD;
        end
      end
      WAIT_BD: begin
        // No current flows yet, so stop may drop straight back to IDLE.
        if (stop_cmd)          state_next = IDLE;
        else if (is_breakdown) state_next = DISCHARGE;
        else if (tmr_done)     state_next = DEAD_A;
      end
      DISCHARGE: begin
        if (stop_cmd || tmr_done) state_next = DEAD_A;
      end
      DEAD_A: begin
        if (tmr_done) state_next = DEION;
      end
      DEION: begin
        if (tmr_done) state_next = DEAD_B;
      end
      DEAD_B: begin
        if (tmr_done) begin
          if (run_next) begin
            state_next = WAIT_BD;
          end else begin
            state_next  = IDLE;
            single_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, mode flags, config shadows and registered outputs.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      run          <= 1'b0;
      single       <= 1'b0;
      ton_q        <= '0;
      toff_q       <= '0;
      gap_en       <= 1'b0;
      discharge_en <= 1'b0;
      deion_en     <= 1'b0;
      busy         <= 1'b0;
      pulse_done   <= 1'b0;
      open_circuit <= 1'b0;
      pulse_count  <= '0;
    end else begin
      state        <= state_next;
      run          <= run_next;
      single       <= single_next;
      gap_en       <= (state_next == WAIT_BD);
      discharge_en <= (state_next == DISCHARGE);
      deion_en     <= (state_next == DEION);
      busy         <= (state_next != IDLE);
      // Only a timeout leaves WAIT_BD for DEAD_A.
      open_circuit <= (state == WAIT_BD) && (state_next == DEAD_A);
      // Registered one cycle early so the strobe lands on the last DEION cycle.
      pulse_done   <= (state == DEION) && tmr_near;
      if ((state == DISCHARGE) && (state_next != DISCHARGE))
        pulse_count <= pulse_count + 16'd1;
      if ((state_next == WAIT_BD) && (state != WAIT_BD)) begin
        ton_q  <= ton_us;
        toff_q <= toff_us;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_discharge_sequencer.sv
// Scoreboard bench for discharge_sequencer. Stimulus pushes the expected
// sequence of state segments (state, length, strobe, pulse_count, next
// state); a monitor closes each segment when state_o changes and compares.
// The breakdown timeout is shortened to 40 us to keep the run short.
module tb_discharge_sequencer;

  localparam int CLK_PER_US = 50;
  localparam int DEAD       = 10;
  localparam int TIMEOUT_US = 40;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_DIS   = 3'd2;
  localparam logic [2:0] S_DA    = 3'd3;
  localparam logic [2:0] S_DEION = 3'd4;
  localparam logic [2:0] S_DB    = 3'd5;

  logic        clk_in       = 1'b0;
  logic        sys_rst_n    = 1'b0;
  logic        start_cmd    = 1'b0;
  logic        stop_cmd     = 1'b0;
  logic        single_cmd   = 1'b0;
  logic        is_breakdown = 1'b0;
  logic [15:0] ton_us       = 16'd0;
  logic [15:0] toff_us      = 16'd0;
  logic        gap_en, discharge_en, deion_en, busy, pulse_done, open_circuit;
  logic [15:0] pulse_count;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;

  // strobe: 0 = none, 1 = one strobe at the right place
  // (pulse_done on the last DEION cycle, open_circuit on the first DEAD_A cycle).
  typedef struct {
    logic [2:0] st;
    int         len;    // -1: not compared
    int         strobe;
    int         cnt;
    logic [2:0] nxt;
  } seg_t;

  seg_t sb[$];

  always #5 clk_in = ~clk_in;

  discharge_sequencer #(
    .CLK_PER_US      (CLK_PER_US),
    .DEAD_CYCLES     (DEAD),
    .WAIT_TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk_in       (clk_in),
    .sys_rst_n    (sys_rst_n),
    .start_cmd    (start_cmd),
    .stop_cmd     (stop_cmd),
    .single_cmd   (single_cmd),
    .ton_us       (ton_us),
    .toff_us      (toff_us),
    .is_breakdown (is_breakdown),
    .gap_en       (gap_en),
    .discharge_en (discharge_en),
    .deion_en     (deion_en),
    .busy         (busy),
    .pulse_done   (pulse_done),
    .open_circuit (open_circuit),
    .pulse_count  (pulse_count),
    .state_o      (state_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic exp_seg(input logic [2:0] st, input int len, input int strobe,
                         input int cnt, input logic [2:0] nxt);
    seg_t s;
    s.st = st; s.len = len; s.strobe = strobe; s.cnt = cnt; s.nxt = nxt;
    sb.push_back(s);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One-cycle command pulse; returns in the first cycle after it was sampled.
  task automatic issue(input logic s, input logic p, input logic g);
    start_cmd  = s;
    stop_cmd   = p;
    single_cmd = g;
    @(posedge clk_in);
    #1;
    start_cmd  = 1'b0;
    stop_cmd   = 1'b0;
    single_cmd = 1'b0;
  endtask

  // Bounded wait for IDLE, then confirm every expected segment was seen.
  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (busy && n < budget);
    @(negedge clk_in);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_drained"}, sb.size(), 32'd0);
  endtask

  // Monitor: per-cycle drive map and segment scoreboard.
  initial begin : monitor
    logic [2:0] cur;
    int len, pd_cnt, pd_at, oc_cnt, oc_at, cnt, seg_no, obs;
    seg_t e;
    cur = S_IDLE; len = 0; pd_cnt = 0; pd_at = 0; oc_cnt = 0; oc_at = 0;
    cnt = 0; seg_no = 0;
    forever begin
      @(negedge clk_in);
      check("drive_map", {28'd0, gap_en, discharge_en, deion_en, busy},
            {28'd0, state_o == S_WAIT, state_o == S_DIS, state_o == S_DEION,
             state_o != S_IDLE});
      if (state_o !== cur) begin
        if (cur != S_IDLE) begin
          seg_no++;
          if (pd_cnt + oc_cnt == 0) obs = 0;
          else if (pd_cnt + oc_cnt == 1 &&
                   ((cur == S_DEION && pd_cnt == 1 && pd_at == len) ||
                    (cur == S_DA && oc_cnt == 1 && oc_at == 1))) obs = 1;
          else obs = 2;
          check($sformatf("seg%0d_expected", seg_no), {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("seg%0d_state", seg_no), cur, e.st);
            if (e.len >= 0) check($sformatf("seg%0d_len", seg_no), len, e.len);
            check($sformatf("seg%0d_strobe", seg_no), obs, e.strobe);
            check($sformatf("seg%0d_count", seg_no), cnt, e.cnt);
            check($sformatf("seg%0d_next", seg_no), state_o, e.nxt);
          end
        end
        cur = state_o; len = 1; pd_cnt = 0; pd_at = 0; oc_cnt = 0; oc_at = 0;
      end else if (cur != S_IDLE) begin
        len++;
      end
      if (cur != S_IDLE) begin
        if (pulse_done)   begin pd_cnt++; pd_at = len; end
        if (open_circuit) begin oc_cnt++; oc_at = len; end
        cnt = pulse_count;
      end
    end
  end

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset values.
    repeat (3) @(negedge clk_in);
    check("rst_state", state_o, 32'd0);
    check("rst_outs", {26'd0, gap_en, discharge_en, deion_en, busy, pulse_done,
          open_circuit}, 32'd0);
    check("rst_count", pulse_count, 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Config guard: ton=0 ignores start; toff=0 ignores single.
    ton_us = 16'd0; toff_us = 16'd50;
    issue(1'b1, 1'b0, 1'b0);
    check("guard_ton0_state", state_o, 32'd0);
    ton_us = 16'd100; toff_us = 16'd0;
    issue(1'b0, 1'b0, 1'b1);
    check("guard_toff0_state", state_o, 32'd0);
    // start and stop together: stop wins.
    toff_us = 16'd50;
    issue(1'b1, 1'b1, 1'b0);
    check("start_stop_state", state_o, 32'd0);
    check("start_stop_busy", {31'd0, busy}, 32'd0);

    // Single shot: ton=100 us, toff=50 us, breakdown 20 us into WAIT_BD.
    exp_seg(S_WAIT,  1000, 0, 0, S_DIS);
    exp_seg(S_DIS,   5000, 0, 0, S_DA);
    exp_seg(S_DA,    DEAD, 0, 1, S_DEION);
    exp_seg(S_DEION, 2500, 1, 1, S_DB);
    exp_seg(S_DB,    DEAD, 0, 1, S_IDLE);
    issue(1'b0, 1'b0, 1'b1);
    wait_cycles(999);
    is_breakdown = 1'b1;
    wait_idle("single", 9000);
    is_breakdown = 1'b0;
    check("single_count", pulse_count, 32'd1);

    // Continuous: breakdown held high, ton 10 us (4 us from pulse 3), toff 5 us.
    ton_us = 16'd10; toff_us = 16'd5; is_breakdown = 1'b1;
    for (int p = 0; p < 3; p++) begin
      exp_seg(S_WAIT,  1, 0, 1 + p, S_DIS);
      exp_seg(S_DIS,   (p == 2) ? 200 : 500, 0, 1 + p, S_DA);
      exp_seg(S_DA,    DEAD, 0, 2 + p, S_DEION);
      exp_seg(S_DEION, 250, 1, 2 + p, S_DB);
      exp_seg(S_DB,    DEAD, 0, 2 + p, (p == 2) ? S_IDLE : S_WAIT);
    end
    issue(1'b1, 1'b0, 1'b0);
    wait_cycles(871);            // inside the second DISCHARGE
    ton_us = 16'd4;
    wait_cycles(1135);           // inside the third DEAD_B
    issue(1'b0, 1'b1, 1'b0);
    wait_idle("cont", 3000);
    is_breakdown = 1'b0;
    check("cont_count", pulse_count, 32'd4);

    // Stop 1000 cycles into DISCHARGE; DEION still runs in full.
    ton_us = 16'd100; toff_us = 16'd50;
    exp_seg(S_WAIT,  10,   0, 4, S_DIS);
    exp_seg(S_DIS,   1000, 0, 4, S_DA);
    exp_seg(S_DA,    DEAD, 0, 5, S_DEION);
    exp_seg(S_DEION, 2500, 1, 5, S_DB);
    exp_seg(S_DB,    DEAD, 0, 5, S_IDLE);
    issue(1'b1, 1'b0, 1'b0);
    wait_cycles(9);
    is_breakdown = 1'b1;
    wait_cycles(1000);
    issue(1'b0, 1'b1, 1'b0);
    is_breakdown = 1'b0;
    wait_idle("stop", 4000);

    // Open circuit: no breakdown, timeout after 40 us, then a second wait
    // that stop ends immediately.
    toff_us = 16'd2;
    exp_seg(S_WAIT,  TIMEOUT_US * CLK_PER_US, 0, 5, S_DA);
    exp_seg(S_DA,    DEAD, 1, 5, S_DEION);
    exp_seg(S_DEION, 100,  1, 5, S_DB);
    exp_seg(S_DB,    DEAD, 0, 5, S_WAIT);
    exp_seg(S_WAIT,  31,   0, 5, S_IDLE);
    issue(1'b1, 1'b0, 1'b0);
    wait_cycles(2150);
    issue(1'b0, 1'b1, 1'b0);
    wait_idle("open", 100);
    check("open_count", pulse_count, 32'd5);

    // Asynchronous reset in the middle of DEION.
    ton_us = 16'd2; toff_us = 16'd10; is_breakdown = 1'b1;
    exp_seg(S_WAIT,  1,    0, 5, S_DIS);
    exp_seg(S_DIS,   100,  0, 5, S_DA);
    exp_seg(S_DA,    DEAD, 0, 6, S_DEION);
    exp_seg(S_DEION, -1,   0, 6, S_IDLE);
    issue(1'b0, 1'b0, 1'b1);
    wait_cycles(300);
    check("pre_rst_deion", {31'd0, deion_en}, 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_deion", {31'd0, deion_en}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_state", state_o, 32'd0);
    is_breakdown = 1'b0;
    repeat (2) @(negedge clk_in);
    sys_rst_n = 1'b1;
    wait_idle("rst", 100);
    check("rst_count_cleared", pulse_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
